// File: rtl/icache_mshr_slot_pkg.sv
// Shared types for the I-cache MSHR slot: FSM state encoding, the default-width
// request record and the way-width helper.
package toy_pack;

  localparam int MSHR_ENTRY_NUM_DEF = 8;
  localparam int WAY_NUM_DEF        = 4;
  localparam int INDEX_W_DEF        = 7;
  localparam int TXNID_W_DEF        = 6;
  localparam int REQ_PLD_W_DEF      = 64;
  localparam int FILL_BEATS_DEF     = 4;

  // A single-way cache still carries a 1-bit way field.
  function automatic int calc_way_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_HZ   = 3'd1,
    RD_DATA   = 3'd2,
    REQ_FILL  = 3'd3,
    WAIT_FILL = 3'd4,
    RELEASE   = 3'd5
  } mshr_slot_state_e;

  typedef struct packed {
    logic [REQ_PLD_W_DEF-1:0]           pld;
    logic [INDEX_W_DEF-1:0]             index;
    logic [TXNID_W_DEF-1:0]             txnid;
    logic [calc_way_w(WAY_NUM_DEF)-1:0] way;
    logic                               hit;
    logic                               pref;
    logic                               snp;
  } mshr_slot_rec_t;

endpackage

// File: rtl/icache_mshr_slot_if.sv
// Slot-facing bus: allocation, hazard release, data-RAM read, linefill request/data.
interface icache_mshr_slot_if
  import toy_pack::*;
#(
  parameter int MSHR_ENTRY_NUM = MSHR_ENTRY_NUM_DEF,
  parameter int WAY_NUM        = WAY_NUM_DEF,
  parameter int INDEX_W        = INDEX_W_DEF,
  parameter int TXNID_W        = TXNID_W_DEF,
  parameter int REQ_PLD_W      = REQ_PLD_W_DEF
) ();
  localparam int WAY_W = calc_way_w(WAY_NUM);

  logic                      alloc_en;
  logic [REQ_PLD_W-1:0]      alloc_pld;
  logic [INDEX_W-1:0]        alloc_index;
  logic [TXNID_W-1:0]        alloc_txnid;
  logic [WAY_W-1:0]          alloc_way;
  logic                      alloc_hit;
  logic                      alloc_pref;
  logic                      alloc_snp;
  logic [MSHR_ENTRY_NUM-1:0] alloc_bitmap;
  logic [MSHR_ENTRY_NUM-1:0] v_release_en;
  logic                      alloc_vld;
  logic                      entry_active;
  logic                      dataram_rd_vld;
  logic                      dataram_rd_rdy;
  logic [WAY_W-1:0]          dataram_rd_way;
  logic [INDEX_W-1:0]        dataram_rd_index;
  logic [TXNID_W-1:0]        dataram_rd_txnid;
  logic                      txreq_vld;
  logic                      txreq_rdy;
  logic [REQ_PLD_W-1:0]      txreq_pld;
  logic                      fill_vld;
  logic [TXNID_W-1:0]        fill_txnid;
  logic                      fill_last;
  logic                      release_en;
  logic                      fill_err;

  modport slave (
    input  alloc_en, alloc_pld, alloc_index, alloc_txnid, alloc_way,
           alloc_hit, alloc_pref, alloc_snp, alloc_bitmap, v_release_en,
           dataram_rd_rdy, txreq_rdy, fill_vld, fill_txnid, fill_last,
    output alloc_vld, entry_active, dataram_rd_vld, dataram_rd_way,
           dataram_rd_index, dataram_rd_txnid, txreq_vld, txreq_pld,
           release_en, fill_err
  );

  modport master (
    output alloc_en, alloc_pld, alloc_index, alloc_txnid, alloc_way,
           alloc_hit, alloc_pref, alloc_snp, alloc_bitmap, v_release_en,
           dataram_rd_rdy, txreq_rdy, fill_vld, fill_txnid, fill_last,
    input  alloc_vld, entry_active, dataram_rd_vld, dataram_rd_way,
           dataram_rd_index, dataram_rd_txnid, txreq_vld, txreq_pld,
           release_en, fill_err
  );
endinterface

// File: rtl/icache_mshr_slot.sv
// One I-cache MSHR entry: waits out older same-set slots, then issues a data-RAM
// read (hit) or a linefill followed by a replay read (miss), then pulses release.
module icache_mshr_slot
  import toy_pack::*;
#(
  parameter int MSHR_ENTRY_NUM = MSHR_ENTRY_NUM_DEF,
  parameter int SLOT_ID        = 0,
  parameter int WAY_NUM        = WAY_NUM_DEF,
  parameter int INDEX_W        = INDEX_W_DEF,
  parameter int TXNID_W        = TXNID_W_DEF,
  parameter int REQ_PLD_W      = REQ_PLD_W_DEF,
  parameter int FILL_BEATS     = FILL_BEATS_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  icache_mshr_slot_if.slave   bus
);
  localparam int WAY_W = calc_way_w(WAY_NUM);
  localparam int CNT_W = $clog2(FILL_BEATS + 1);

  typedef struct packed {
    logic [REQ_PLD_W-1:0] pld;
    logic [INDEX_W-1:0]   index;
    logic [TXNID_W-1:0]   txnid;
    logic [WAY_W-1:0]     way;
    logic                 hit;
    logic                 pref;
    logic                 snp;
  } rec_t;

  mshr_slot_state_e          r_state, w_state_nxt;
  rec_t                      r_rec, w_rec_nxt;
  logic [MSHR_ENTRY_NUM-1:0] r_bitmap, w_bitmap_nxt;
  logic [CNT_W-1:0]          r_cnt, w_cnt_nxt;
  logic                      r_fill_err, w_fill_err_nxt;

  logic             w_rd_vld, w_tx_vld, w_rel;
  logic             w_beat, w_full;
  logic [CNT_W-1:0] w_cnt_inc;

  assign w_beat    = bus.fill_vld && (bus.fill_txnid == r_rec.txnid);
  assign w_cnt_inc = r_cnt + 1'b1;
  assign w_full    = (w_cnt_inc == CNT_W'(FILL_BEATS));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_rec      <= '0;
      r_bitmap   <= '0;
      r_cnt      <= '0;
      r_fill_err <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_rec      <= w_rec_nxt;
      r_bitmap   <= w_bitmap_nxt;
      r_cnt      <= w_cnt_nxt;
      r_fill_err <= w_fill_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_rec_nxt      = r_rec;
    w_bitmap_nxt   = r_bitmap & ~bus.v_release_en;
    w_cnt_nxt      = r_cnt;
    w_fill_err_nxt = r_fill_err;
    w_rd_vld       = 1'b0;
    w_tx_vld       = 1'b0;
    w_rel          = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.alloc_en) begin
          w_rec_nxt.pld   = bus.alloc_pld;
          w_rec_nxt.index = bus.alloc_index;
          w_rec_nxt.txnid = bus.alloc_txnid;
          w_rec_nxt.way   = bus.alloc_way;
          w_rec_nxt.hit   = bus.alloc_hit;
          w_rec_nxt.pref  = bus.alloc_pref;
          w_rec_nxt.snp   = bus.alloc_snp;
          // Same-cycle releases are masked here so they are never lost.
          w_bitmap_nxt          = bus.alloc_bitmap & ~bus.v_release_en;
          w_bitmap_nxt[SLOT_ID] = 1'b0;
          w_cnt_nxt             = '0;
          w_fill_err_nxt        = 1'b0;
          w_state_nxt           = bus.alloc_snp ? RELEASE : WAIT_HZ;
        end
      end
      WAIT_HZ: begin
        // Request issues straight from here so alloc-to-vld is a single cycle.
        if (r_bitmap == '0 && !r_rec.snp) begin
          if (r_rec.hit) begin
            w_rd_vld    = 1'b1;
            w_state_nxt = bus.dataram_rd_rdy ? RELEASE : RD_DATA;
          end else begin
            w_tx_vld = 1'b1;
            if (bus.txreq_rdy) begin
              w_cnt_nxt   = '0;
              w_state_nxt = WAIT_FILL;
            end else begin
              w_state_nxt = REQ_FILL;
            end
          end
        end
      end
      RD_DATA: begin
        w_rd_vld = 1'b1;
        if (bus.dataram_rd_rdy) w_state_nxt = RELEASE;
      end
      REQ_FILL: begin
        w_tx_vld = 1'b1;
        if (bus.txreq_rdy) begin
          w_cnt_nxt   = '0;
          w_state_nxt = WAIT_FILL;
        end
      end
      WAIT_FILL: begin
        if (w_beat) begin
          if (w_full || bus.fill_last) begin
            if (bus.fill_last && !w_full) w_fill_err_nxt = 1'b1;
            w_state_nxt = r_rec.pref ? RELEASE : RD_DATA;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
      end
      RELEASE: begin
        w_rel       = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign bus.alloc_vld        = (r_state == IDLE);
  assign bus.entry_active     = (r_state != IDLE);
  assign bus.dataram_rd_vld   = w_rd_vld;
  assign bus.dataram_rd_way   = r_rec.way;
  assign bus.dataram_rd_index = r_rec.index;
  assign bus.dataram_rd_txnid = r_rec.txnid;
  assign bus.txreq_vld        = w_tx_vld;
  assign bus.txreq_pld        = r_rec.pld;
  assign bus.release_en       = w_rel;
  assign bus.fill_err         = r_fill_err;

endmodule
